// File: rtl/mul_fifo_core.sv
// mul_fifo_core: sequential half of the 8-entry calculation FIFO; optional err_cnt output under MUL_FIFO_ERR_CNT_EN.
// Latency: a request in cycle N shows its ack/err state in cycle N+1; the pop data appears in dout one cycle after READ.
// No backpressure: a write to a full FIFO is rejected as WR_ERROR, and a read from an empty FIFO is rejected as RD_ERROR.
module mul_fifo_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  we,
    input  logic                  re,
    input  logic [2:0]            next_head,
    input  logic [2:0]            next_tail,
    input  logic [3:0]            next_data_count,
    output logic [2:0]            state,
    output logic [2:0]            head,
    output logic [2:0]            tail,
    output logic [3:0]            data_count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
`ifdef MUL_FIFO_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        WRITE    = 3'b010,
        WR_ERROR = 3'b011,
        READ     = 3'b100,
        RD_ERROR = 3'b101
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] mem [8];

    // next_data_count already reflects the operation in flight, so back-to-back requests see true fullness
    always_comb begin
        state_d = NO_OP;
        if (wr_en && !rd_en) begin
            state_d = (next_data_count == 4'd8) ? WR_ERROR : WRITE;
        end else if (rd_en && !wr_en) begin
            state_d = (next_data_count == 4'd0) ? RD_ERROR : READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            head       <= 3'd0;
            tail       <= 3'd0;
            data_count <= 4'd0;
            dout       <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            head       <= next_head;
            tail       <= next_tail;
            data_count <= next_data_count;
            if (wr_en) begin
                din_q <= din;
            end
            if (re) begin
                dout <= mem[head];
            end
        end
    end

    // Storage has no reset; gating on reset drops a write whose WRITE state is cut short
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem[tail] <= din_q;
        end
    end

`ifdef MUL_FIFO_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if ((state_q == WR_ERROR || state_q == RD_ERROR) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    assign state  = state_q;
    assign full   = (data_count == 4'd8);
    assign empty  = (data_count == 4'd0);
    assign wr_ack = (state_q == WRITE);
    assign wr_err = (state_q == WR_ERROR);
    assign rd_ack = (state_q == READ);
    assign rd_err = (state_q == RD_ERROR);

endmodule

// File: tb/tb_mul_fifo_core.sv
// Bench for mul_fifo_core: a behavioural calculator closes the loop, and a queue-based model predicts every output each cycle.
module tb_mul_fifo_core;

    localparam logic [2:0] S_INIT = 3'd0, S_NOOP = 3'd1, S_WR = 3'd2,
                           S_WERR = 3'd3, S_RD = 3'd4, S_RERR = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] din = '0;
    logic        we, re;
    logic [2:0]  next_head, next_tail;
    logic [3:0]  next_data_count;
    logic [2:0]  state, head, tail;
    logic [3:0]  data_count;
    logic [31:0] dout;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef MUL_FIFO_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    mul_fifo_core #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
        .we(we), .re(re), .next_head(next_head), .next_tail(next_tail),
        .next_data_count(next_data_count), .state(state), .head(head), .tail(tail),
        .data_count(data_count), .dout(dout), .full(full), .empty(empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
`ifdef MUL_FIFO_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Combinational FIFO calculator that the core expects alongside it
    always_comb begin
        we = (state == S_WR);
        re = (state == S_RD) || (((state == S_NOOP) || (state == S_WERR)) && (data_count != 4'd0));
        next_tail = tail + {2'b00, we};
        next_head = head + {2'b00, (state == S_RD)};
        next_data_count = data_count + {3'b000, we} - {3'b000, (state == S_RD)};
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, plus the state the last request produced
    logic [31:0] q[$];
    logic [2:0]  m_state;
    int          m_head, m_tail, m_errs;
    logic [31:0] m_dout, m_dinq;
    bit          m_valid = 0;

    task automatic step(input logic w, input logic r, input logic [31:0] d, input logic rs);
        wr_en = w; rd_en = r; din = d; reset = rs;
        @(negedge clk);
        if (m_valid) begin
            chk("state", 64'(state), 64'(m_state));
            chk("head", 64'(head), 64'(m_head));
            chk("tail", 64'(tail), 64'(m_tail));
            chk("count", 64'(data_count), 64'(q.size()));
            chk("dout", 64'(dout), 64'(m_dout));
            chk("full", 64'(full), 64'(q.size() == 8));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("wr_ack", 64'(wr_ack), 64'(m_state == S_WR));
            chk("wr_err", 64'(wr_err), 64'(m_state == S_WERR));
            chk("rd_ack", 64'(rd_ack), 64'(m_state == S_RD));
            chk("rd_err", 64'(rd_err), 64'(m_state == S_RERR));
`ifdef MUL_FIFO_ERR_CNT_EN
            chk("err_cnt", 64'(err_cnt), 64'(m_errs));
`endif
        end
        if (rs) begin
            q.delete();
            m_state = S_INIT; m_head = 0; m_tail = 0; m_dout = '0; m_dinq = '0;
            m_errs = 0; m_valid = 1;
        end else if (m_valid) begin
            case (m_state)
                S_WR: begin q.push_back(m_dinq); m_tail = (m_tail + 1) % 8; end
                S_RD: begin m_dout = q.pop_front(); m_head = (m_head + 1) % 8; end
                S_NOOP, S_WERR: if (q.size() > 0) m_dout = q[0];
                default: ;
            endcase
            if ((m_state == S_WERR || m_state == S_RERR) && m_errs < 255) m_errs++;
            if (w && !r)      m_state = (q.size() == 8) ? S_WERR : S_WR;
            else if (r && !w) m_state = (q.size() == 0) ? S_RERR : S_RD;
            else              m_state = S_NOOP;
            if (w) m_dinq = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rst();
        step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        rst(); rst();
        idle(3);

        step(1, 0, 32'h11, 0); step(1, 0, 32'h22, 0); step(1, 0, 32'h33, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0, 0);
        idle(3);

        rst();
        for (int i = 0; i < 9; i++) step(1, 0, 32'h100 + 32'(i), 0);
        idle(1);
        for (int i = 0; i < 9; i++) step(0, 1, 32'h0, 0);
        idle(2);

        rst();
        step(0, 1, 32'h0, 0);
        idle(3);

        rst();
        for (int i = 0; i < 8; i++) step(1, 0, 32'h200 + 32'(i), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 32'h0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 32'h300 + 32'(i), 0);
        idle(2);
        for (int i = 0; i < 8; i++) step(0, 1, 32'h0, 0);
        idle(2);

        rst();
        for (int i = 0; i < 4; i++) step(1, 0, 32'h400 + 32'(i), 0);
        idle(1);
        step(1, 1, 32'hDEAD, 0);
        idle(1);
        step(1, 0, 32'h500, 0);
        step(0, 0, 32'h0, 1);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) rst();
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_fifo_core.md
Name: mul_fifo_core

Overview:
- Sequential half of the 8-entry calculation FIFO.
- Owns the state register, the head/tail/count registers, the 8-deep storage and the output data register.
- Feeds the current state/head/tail/data_count to the combinational FIFO calculator and consumes its we/re/next_* outputs.
- Decodes user wr_en/rd_en requests into the 3-bit FIFO state encoding used across the project.

Parameters:
- DATA_WIDTH, 32, width of din/dout and of each storage entry.
- Depth is fixed at 8 (3-bit pointers, 4-bit count) and is not parameterised.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request this cycle
- rd_en  input  1  read request this cycle
- din  input  DATA_WIDTH  write data, sampled with wr_en
- we  input  1  from calculator: commit write this cycle
- re  input  1  from calculator: load dout this cycle
- next_head  input  3  from calculator
- next_tail  input  3  from calculator
- next_data_count  input  4  from calculator
- state  output  3  registered FIFO state, to calculator
- head  output  3  registered read pointer, to calculator
- tail  output  3  registered write pointer, to calculator
- data_count  output  4  registered occupancy 0..8, to calculator
- dout  output  DATA_WIDTH  registered read data
- full  output  1  data_count==8
- empty  output  1  data_count==0
- wr_ack  output  1  state==WRITE
- wr_err  output  1  state==WR_ERROR
- rd_ack  output  1  state==READ
- rd_err  output  1  state==RD_ERROR

Behaviour:
- State encoding: INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101. Codes 110/111 are unreachable.
- Reset: state=INIT, head=0, tail=0, data_count=0, dout=0, din_q=0. Storage contents are not reset.
- Reset asserted mid-operation discards any pending request; the first post-reset cycle shows state=INIT.
- Next state is computed every cycle from wr_en, rd_en and next_data_count. next_data_count is the occupancy after the operation currently in flight, so back-to-back requests see the correct fullness.
  - wr_en & !rd_en: WR_ERROR if next_data_count==8, else WRITE.
  - rd_en & !wr_en: RD_ERROR if next_data_count==0, else READ.
  - Both or neither: NO_OP. A simultaneous request is ignored, with no ack and no error.
  - From INIT, decisions use the same rules; INIT is only re-entered by reset.
- Pipeline: a request in cycle N sets state in cycle N+1.
  - Storage write, pointer and count updates take effect at the end of cycle N+1.
  - Ack/err are visible during cycle N+1 (1-cycle latency).
- din_q <= din when wr_en. When we==1, mem[tail] <= din_q.
- head <= next_head, tail <= next_tail, data_count <= next_data_count on every non-reset edge.
- dout: when re==1, dout <= mem[head]; otherwise dout holds.
  - In READ, dout captures the popped entry.
  - In NO_OP/WR_ERROR with data, dout refreshes to the current head entry.
- Pointers wrap 7->0 by natural 3-bit overflow. data_count never exceeds 8 or drops below 0 because error states hold it.
- full/empty are combinational from registered data_count.
- Writing when full: WR_ERROR, storage and tail unchanged.
- Reading when empty: RD_ERROR, dout unchanged.

Optional Feature:
- Macro: MUL_FIFO_ERR_CNT_EN.
- When defined, adds output err_cnt [7:0].
  - Reset 0.
  - Increments by 1 on each clock edge where state is WR_ERROR or RD_ERROR.
  - Saturates at 255.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then idle 3 cycles -> state INIT then NO_OP; head=tail=0, data_count=0, empty=1, full=0, dout=0.
- Write 0x11,0x22,0x33 on consecutive cycles, then read 3 -> wr_ack x3, count 3; rd_ack x3 with dout 0x11,0x22,0x33 one cycle after each READ state; empty=1 afterwards.
- Write 9 consecutive values 0x100..0x108 -> 8 wr_ack, full=1 after the 8th; 9th gives wr_err=1, tail=0, count stays 8, and 0x108 is never stored.
- Read from empty after reset -> rd_err=1, dout stays 0, head=0, count 0 (with MUL_FIFO_ERR_CNT_EN: err_cnt=1).
- Fill 8, read 5, write 5 -> tail wraps 0->5, head=5, count 8; subsequent reads return values in FIFO order across the wrap.
- wr_en=rd_en=1 with count 4 -> state NO_OP, count stays 4. Then assert reset during a WRITE state -> next cycle INIT with count 0 and pointers 0.
